// File: rtl/mem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Purpose: bundles the instruction-fetch port, the data port and the byte-wide
// RAM strobe bus of mem_port_arbiter into one interface.
//
// Signal summary:
//   Fetch port : i_req, i_addr[31:0]  -> arbiter ; i_rdata[31:0], i_ack <- arbiter
//   Data port  : d_req, d_rw, d_mode[1:0], d_addr[31:0], d_wdata[31:0],
//                d_wdata2[31:0]       -> arbiter ; d_rdata[31:0], d_rdata2[31:0],
//                d_ack, d_err         <- arbiter
//   RAM bus    : mem_en, mem_we, mem_addr[7:0], mem_wdata[7:0] <- arbiter ;
//                mem_rdata[7:0]       -> arbiter
//   Status     : busy                 <- arbiter
//
// Modports:
//   slave  - the arbiter itself
//   master - the requesters plus the RAM (testbench / surrounding system)
// ----------------------------------------------------------------------------
interface mem_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;

    logic        d_req;
    logic        d_rw;
    logic [1:0]  d_mode;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_wdata2;
    logic [31:0] d_rdata;
    logic [31:0] d_rdata2;
    logic        d_ack;
    logic        d_err;

    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic        busy;

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_rw, d_mode, d_addr, d_wdata, d_wdata2,
        input  mem_rdata,
        output i_rdata, i_ack,
        output d_rdata, d_rdata2, d_ack, d_err,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output i_req, i_addr,
        output d_req, d_rw, d_mode, d_addr, d_wdata, d_wdata2,
        output mem_rdata,
        input  i_rdata, i_ack,
        input  d_rdata, d_rdata2, d_ack, d_err,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose: shares one 256x8 byte-wide RAM (combinational read) between an
// instruction-fetch port (always 4-byte word) and a data port (byte, halfword,
// word, optional doubleword). A three-state FSM (IDLE, ACCESS, DONE) grants one
// port in IDLE with round-robin on ties, moves one byte per cycle in ACCESS
// (big-endian: lowest address is the most significant byte) and pulses the
// matching ack for one cycle in DONE.
//
// Ports:
//   clk      - single clock, rising edge
//   reset_n  - asynchronous active-low reset; abandons any transfer in flight
//   bus      - mem_port_arbiter_if.slave (fetch port, data port, RAM bus, busy)
//
// Configuration:
//   MEM_ARB_DWORD_EN - when defined, d_mode=2'b11 performs an 8-byte transfer
//                      using d_wdata/d_wdata2 and d_rdata/d_rdata2. When not
//                      defined, d_mode=2'b11 is rejected with d_err and
//                      d_rdata2 reads as zero.
// ----------------------------------------------------------------------------
module mem_port_arbiter (
    input  logic                 clk,
    input  logic                 reset_n,
    mem_port_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_last_d;     // 1: last grant went to D, 0: to I
    logic        r_port_d;     // port owning the current transfer
    logic        r_rw;
    logic [2:0]  r_cnt;        // bytes remaining after the current one
    logic [63:0] r_wbuf;       // bytes still to be written, next one in [63:56]
    logic [63:0] r_rbuf;       // bytes read so far, latest in [7:0]
    logic        r_mem_en;
    logic        r_mem_we;
    logic [7:0]  r_mem_addr;
    logic [7:0]  r_mem_wdata;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;
    logic        r_i_ack;
    logic        r_d_ack;
    logic        r_d_err;
    logic        r_busy;
`ifdef MEM_ARB_DWORD_EN
    logic        r_dw;
    logic [31:0] r_d_rdata2;
`endif

    logic        w_grant_d;
    logic        w_grant_i;
    logic [2:0]  w_d_last;     // byte count minus one for the data request
    logic        w_d_bad;      // misaligned or unsupported data request
    logic [63:0] w_d_wbuf;     // data write bytes, left-aligned
    logic [63:0] w_rbuf_next;

    // Round-robin: on a tie the port that did not win last time is granted.
    assign w_grant_d = bus.d_req && (!bus.i_req || !r_last_d);
    assign w_grant_i = bus.i_req && !w_grant_d;

    // Shifting each new byte in at the bottom leaves the first (lowest
    // address) byte most significant and zero-extends short reads.
    assign w_rbuf_next = {r_rbuf[55:0], bus.mem_rdata};

    always_comb begin
        w_d_last = 3'd0;
        w_d_bad  = 1'b0;
        w_d_wbuf = {bus.d_wdata[7:0], 56'd0};
        case (bus.d_mode)
            2'b00: begin
                w_d_last = 3'd0;
                w_d_bad  = 1'b0;
                w_d_wbuf = {bus.d_wdata[7:0], 56'd0};
            end
            2'b01: begin
                w_d_last = 3'd1;
                w_d_bad  = bus.d_addr[0];
                w_d_wbuf = {bus.d_wdata[15:0], 48'd0};
            end
            2'b10: begin
                w_d_last = 3'd3;
                w_d_bad  = |bus.d_addr[1:0];
                w_d_wbuf = {bus.d_wdata, 32'd0};
            end
            default: begin
`ifdef MEM_ARB_DWORD_EN
                w_d_last = 3'd7;
                w_d_bad  = |bus.d_addr[2:0];
                w_d_wbuf = {bus.d_wdata, bus.d_wdata2};
`else
                w_d_last = 3'd0;
                w_d_bad  = 1'b1;
                w_d_wbuf = {bus.d_wdata, 32'd0};
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_last_d    <= 1'b0;
            r_port_d    <= 1'b0;
            r_rw        <= 1'b0;
            r_cnt       <= 3'd0;
            r_wbuf      <= 64'd0;
            r_rbuf      <= 64'd0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 8'd0;
            r_mem_wdata <= 8'd0;
            r_i_rdata   <= 32'd0;
            r_d_rdata   <= 32'd0;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_d_err     <= 1'b0;
            r_busy      <= 1'b0;
`ifdef MEM_ARB_DWORD_EN
            r_dw        <= 1'b0;
            r_d_rdata2  <= 32'd0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_last_d <= 1'b1;
                        r_port_d <= 1'b1;
                        r_busy   <= 1'b1;
                        if (w_d_bad) begin
                            // Rejected requests skip the RAM entirely.
                            r_state <= DONE;
                            r_d_ack <= 1'b1;
                            r_d_err <= 1'b1;
                        end else begin
                            r_state     <= ACCESS;
                            r_rw        <= bus.d_rw;
                            r_cnt       <= w_d_last;
                            r_rbuf      <= 64'd0;
                            r_wbuf      <= {w_d_wbuf[55:0], 8'd0};
                            r_mem_en    <= 1'b1;
                            r_mem_we    <= bus.d_rw;
                            r_mem_addr  <= bus.d_addr[7:0];
                            r_mem_wdata <= w_d_wbuf[63:56];
`ifdef MEM_ARB_DWORD_EN
                            r_dw        <= (bus.d_mode == 2'b11);
`endif
                        end
                    end else if (w_grant_i) begin
                        r_last_d    <= 1'b0;
                        r_port_d    <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ACCESS;
                        r_rw        <= 1'b0;
                        r_cnt       <= 3'd3;
                        r_rbuf      <= 64'd0;
                        r_wbuf      <= 64'd0;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= {bus.i_addr[7:2], 2'b00};
                        r_mem_wdata <= 8'd0;
`ifdef MEM_ARB_DWORD_EN
                        r_dw        <= 1'b0;
`endif
                    end
                end

                ACCESS: begin
                    r_rbuf <= w_rbuf_next;
                    if (r_cnt == 3'd0) begin
                        r_state     <= DONE;
                        r_mem_en    <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= 8'd0;
                        r_mem_wdata <= 8'd0;
                        if (r_port_d) begin
                            r_d_ack <= 1'b1;
                            r_d_err <= 1'b0;
                            if (!r_rw) begin
`ifdef MEM_ARB_DWORD_EN
                                if (r_dw) begin
                                    r_d_rdata  <= w_rbuf_next[63:32];
                                    r_d_rdata2 <= w_rbuf_next[31:0];
                                end else begin
                                    r_d_rdata  <= w_rbuf_next[31:0];
                                end
`else
                                r_d_rdata <= w_rbuf_next[31:0];
`endif
                            end
                        end else begin
                            r_i_ack   <= 1'b1;
                            r_i_rdata <= w_rbuf_next[31:0];
                        end
                    end else begin
                        r_cnt       <= r_cnt - 3'd1;
                        // 8-bit address wraps 255 -> 0 naturally.
                        r_mem_addr  <= r_mem_addr + 8'd1;
                        r_mem_wdata <= r_wbuf[63:56];
                        r_wbuf      <= {r_wbuf[55:0], 8'd0};
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                    r_i_ack <= 1'b0;
                    r_d_ack <= 1'b0;
                    r_d_err <= 1'b0;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.i_rdata   = r_i_rdata;
    assign bus.i_ack     = r_i_ack;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.d_ack     = r_d_ack;
    assign bus.d_err     = r_d_err;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = r_busy;
`ifdef MEM_ARB_DWORD_EN
    assign bus.d_rdata2  = r_d_rdata2;
`else
    assign bus.d_rdata2  = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed testbench for mem_port_arbiter: models the 256x8 RAM with
// combinational read, drives both requester ports and checks results against
// hand-computed expected values. Honours MEM_ARB_DWORD_EN like the design.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic clk;
    logic reset_n;

    mem_port_arbiter_if bus();

    mem_port_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model; the preload port lets the bench set contents while idle.
    logic [7:0] ram [256];
    logic       pl_we;
    logic [7:0] pl_addr;
    logic [7:0] pl_data;

    always @(posedge clk) begin
        if (pl_we)
            ram[pl_addr] <= pl_data;
        else if (bus.mem_en && bus.mem_we)
            ram[bus.mem_addr] <= bus.mem_wdata;
    end

    assign bus.mem_rdata = ram[bus.mem_addr];

    int checks;
    int failures;

    task automatic poke(input logic [7:0] a, input logic [7:0] v);
        @(negedge clk);
        pl_we   = 1'b1;
        pl_addr = a;
        pl_data = v;
        @(negedge clk);
        pl_we   = 1'b0;
    endtask

    task automatic clear_inputs();
        bus.i_req    = 1'b0;
        bus.i_addr   = 32'd0;
        bus.d_req    = 1'b0;
        bus.d_rw     = 1'b0;
        bus.d_mode   = 2'b00;
        bus.d_addr   = 32'd0;
        bus.d_wdata  = 32'd0;
        bus.d_wdata2 = 32'd0;
    endtask

    task automatic do_reset();
        clear_inputs();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic start_i(input logic [31:0] a);
        bus.i_addr = a;
        bus.i_req  = 1'b1;
    endtask

    task automatic start_d(input logic rw, input logic [1:0] m, input logic [31:0] a,
                           input logic [31:0] w, input logic [31:0] w2);
        bus.d_rw     = rw;
        bus.d_mode   = m;
        bus.d_addr   = a;
        bus.d_wdata  = w;
        bus.d_wdata2 = w2;
        bus.d_req    = 1'b1;
    endtask

    // Waits for every currently raised request to be acked; latencies are
    // counted in falling edges after the request was driven.
    task automatic run_until_ack(output int lat_i, output int lat_d,
                                 output logic err, output logic saw_en);
        bit want_i;
        bit want_d;
        int n;
        want_i = bus.i_req;
        want_d = bus.d_req;
        lat_i  = -1;
        lat_d  = -1;
        err    = 1'b0;
        saw_en = 1'b0;
        n      = 0;
        while ((want_i || want_d) && n < 60) begin
            @(negedge clk);
            n++;
            if (bus.mem_en) saw_en = 1'b1;
            if (want_i && bus.i_ack) begin
                lat_i = n; want_i = 1'b0; bus.i_req = 1'b0;
            end
            if (want_d && bus.d_ack) begin
                lat_d = n; err = bus.d_err; want_d = 1'b0; bus.d_req = 1'b0;
            end
        end
        checks++;
        if (want_i || want_d) begin
            failures++;
            $display("FAIL ack_timeout pending_i=%0d pending_d=%0d required=none", want_i, want_d);
            bus.i_req = 1'b0;
            bus.d_req = 1'b0;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        pl_we = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%h exp=0", bus.busy); end
        checks++; if (bus.i_ack !== 1'b0) begin failures++; $display("FAIL rst_i_ack got=%h exp=0", bus.i_ack); end
        checks++; if (bus.d_ack !== 1'b0) begin failures++; $display("FAIL rst_d_ack got=%h exp=0", bus.d_ack); end
        checks++; if (bus.d_err !== 1'b0) begin failures++; $display("FAIL rst_d_err got=%h exp=0", bus.d_err); end
        checks++; if ({bus.mem_en, bus.mem_we} !== 2'b00) begin failures++; $display("FAIL rst_mem_strobes got=%b exp=00", {bus.mem_en, bus.mem_we}); end
        checks++; if ({bus.mem_addr, bus.mem_wdata} !== 16'h0) begin failures++; $display("FAIL rst_mem_bus got=%h exp=0000", {bus.mem_addr, bus.mem_wdata}); end
        checks++; if (bus.i_rdata !== 32'h0) begin failures++; $display("FAIL rst_i_rdata got=%h exp=0", bus.i_rdata); end
        checks++; if ({bus.d_rdata, bus.d_rdata2} !== 64'h0) begin failures++; $display("FAIL rst_d_rdata got=%h exp=0", {bus.d_rdata, bus.d_rdata2}); end
        reset_n = 1'b1;
    endtask

    task automatic test_fetch();
        int li, ld; logic e, en;
        poke(8'h00, 8'h12); poke(8'h01, 8'h34); poke(8'h02, 8'h56); poke(8'h03, 8'h78);
        @(negedge clk);
        start_i(32'hFFFF_FF03);
        run_until_ack(li, ld, e, en);
        checks++; if (li !== 5) begin failures++; $display("FAIL fetch_latency got=%0d exp=5", li); end
        checks++; if (bus.i_rdata !== 32'h12345678) begin failures++; $display("FAIL fetch_data got=%h exp=12345678", bus.i_rdata); end
        @(negedge clk);
        checks++; if ({bus.i_ack, bus.busy} !== 2'b00) begin failures++; $display("FAIL fetch_ack_pulse got=%b exp=00", {bus.i_ack, bus.busy}); end
    endtask

    task automatic test_arbitration();
        int li, ld; logic e, en;
        do_reset();
        @(negedge clk);
        start_i(32'h0); start_d(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        run_until_ack(li, ld, e, en);
        checks++; if (ld !== 2 || li !== 8) begin failures++; $display("FAIL tie1_order got_d=%0d got_i=%0d exp_d=2 exp_i=8", ld, li); end
        checks++; if (bus.d_rdata !== 32'h12) begin failures++; $display("FAIL tie1_d_data got=%h exp=00000012", bus.d_rdata); end
        checks++; if (bus.i_rdata !== 32'h12345678) begin failures++; $display("FAIL tie1_i_data got=%h exp=12345678", bus.i_rdata); end
        @(negedge clk);
        start_d(1'b0, 2'b00, 32'h1, 32'h0, 32'h0);
        run_until_ack(li, ld, e, en);
        checks++; if (ld !== 2 || bus.d_rdata !== 32'h34) begin failures++; $display("FAIL single_d got_lat=%0d got=%h exp_lat=2 exp=00000034", ld, bus.d_rdata); end
        @(negedge clk);
        start_i(32'h0); start_d(1'b0, 2'b00, 32'h2, 32'h0, 32'h0);
        run_until_ack(li, ld, e, en);
        checks++; if (li !== 5 || ld !== 8) begin failures++; $display("FAIL tie2_order got_i=%0d got_d=%0d exp_i=5 exp_d=8", li, ld); end
        checks++; if (bus.d_rdata !== 32'h56) begin failures++; $display("FAIL tie2_d_data got=%h exp=00000056", bus.d_rdata); end
    endtask

    task automatic test_write_read();
        int li, ld; logic e, en;
        @(negedge clk);
        start_d(1'b1, 2'b10, 32'hABCD_0008, 32'hAABBCCDD, 32'h0);
        run_until_ack(li, ld, e, en);
        checks++; if (ld !== 5 || e !== 1'b0) begin failures++; $display("FAIL word_write got_lat=%0d got_err=%b exp_lat=5 exp_err=0", ld, e); end
        checks++; if ({ram[8], ram[9], ram[10], ram[11]} !== 32'hAABBCCDD) begin failures++; $display("FAIL word_write_ram got=%h exp=aabbccdd", {ram[8], ram[9], ram[10], ram[11]}); end
        checks++; if (bus.d_rdata !== 32'h56) begin failures++; $display("FAIL write_keeps_rdata got=%h exp=00000056", bus.d_rdata); end
        @(negedge clk);
        start_d(1'b0, 2'b00, 32'h9, 32'hFFFF_FFFF, 32'h0);
        run_until_ack(li, ld, e, en);
        checks++; if (bus.d_rdata !== 32'h000000BB || e !== 1'b0) begin failures++; $display("FAIL byte_read got=%h err=%b exp=000000bb err=0", bus.d_rdata, e); end
        @(negedge clk);
        start_d(1'b0, 2'b01, 32'hA, 32'h0, 32'h0);
        run_until_ack(li, ld, e, en);
        checks++; if (bus.d_rdata !== 32'h0000CCDD || ld !== 3) begin failures++; $display("FAIL half_read got=%h lat=%0d exp=0000ccdd lat=3", bus.d_rdata, ld); end
        @(negedge clk);
        start_d(1'b1, 2'b01, 32'h20, 32'h1234_BEEF, 32'h0);
        run_until_ack(li, ld, e, en);
        checks++; if ({ram[8'h20], ram[8'h21]} !== 16'hBEEF) begin failures++; $display("FAIL half_write_ram got=%h exp=beef", {ram[8'h20], ram[8'h21]}); end
    endtask

    task automatic test_misaligned();
        int li, ld; logic e, en;
        @(negedge clk);
        start_d(1'b0, 2'b01, 32'h3, 32'h0, 32'h0);
        run_until_ack(li, ld, e, en);
        checks++; if (ld !== 1 || e !== 1'b1) begin failures++; $display("FAIL misaligned_half got_lat=%0d got_err=%b exp_lat=1 exp_err=1", ld, e); end
        checks++; if (en !== 1'b0) begin failures++; $display("FAIL misaligned_mem_en got=%b exp=0", en); end
        checks++; if (bus.d_rdata !== 32'h0000CCDD) begin failures++; $display("FAIL misaligned_rdata got=%h exp=0000ccdd", bus.d_rdata); end
        @(negedge clk);
        start_d(1'b1, 2'b10, 32'h22, 32'h0, 32'h0);
        run_until_ack(li, ld, e, en);
        checks++; if (e !== 1'b1 || en !== 1'b0) begin failures++; $display("FAIL misaligned_word got_err=%b got_en=%b exp_err=1 exp_en=0", e, en); end
    endtask

    task automatic test_dword();
        int li, ld; logic e, en;
        for (int k = 0; k < 8; k++) poke(8'hF8 + 8'(k), 8'(k + 1));
        @(negedge clk);
        start_d(1'b0, 2'b11, 32'hF8, 32'h0, 32'h0);
        run_until_ack(li, ld, e, en);
`ifdef MEM_ARB_DWORD_EN
        checks++; if (ld !== 9 || e !== 1'b0) begin failures++; $display("FAIL dword_read got_lat=%0d got_err=%b exp_lat=9 exp_err=0", ld, e); end
        checks++; if ({bus.d_rdata, bus.d_rdata2} !== 64'h0102030405060708) begin failures++; $display("FAIL dword_data got=%h exp=0102030405060708", {bus.d_rdata, bus.d_rdata2}); end
        @(negedge clk);
        start_d(1'b1, 2'b11, 32'h30, 32'h11223344, 32'h55667788);
        run_until_ack(li, ld, e, en);
        checks++; if ({ram[8'h30], ram[8'h33], ram[8'h34], ram[8'h37]} !== 32'h11445588) begin failures++; $display("FAIL dword_write_ram got=%h exp=11445588", {ram[8'h30], ram[8'h33], ram[8'h34], ram[8'h37]}); end
`else
        checks++; if (ld !== 1 || e !== 1'b1 || en !== 1'b0) begin failures++; $display("FAIL dword_reject got_lat=%0d err=%b en=%b exp_lat=1 err=1 en=0", ld, e, en); end
        checks++; if (bus.d_rdata2 !== 32'h0 || bus.d_rdata !== 32'h0000CCDD) begin failures++; $display("FAIL dword_reject_data got=%h_%h exp=0000ccdd_00000000", bus.d_rdata, bus.d_rdata2); end
`endif
    endtask

    task automatic test_wrap_reset();
        int li, ld; logic e, en;
        logic acked;
        @(negedge clk);
        start_d(1'b1, 2'b10, 32'hFC, 32'hA1B2C3D4, 32'h0);
        run_until_ack(li, ld, e, en);
        checks++; if ({ram[8'hFC], ram[8'hFD], ram[8'hFE], ram[8'hFF]} !== 32'hA1B2C3D4) begin failures++; $display("FAIL top_word_ram got=%h exp=a1b2c3d4", {ram[8'hFC], ram[8'hFD], ram[8'hFE], ram[8'hFF]}); end
        @(negedge clk);
        start_d(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        run_until_ack(li, ld, e, en);
        checks++; if (bus.d_rdata !== 32'h12) begin failures++; $display("FAIL no_wrap_byte0 got=%h exp=00000012", bus.d_rdata); end
        poke(8'hFC, 8'h11); poke(8'hFD, 8'h22); poke(8'hFE, 8'h33); poke(8'hFF, 8'h44);
        @(negedge clk);
        start_d(1'b1, 2'b10, 32'hFC, 32'hE5F60718, 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if ({bus.busy, bus.mem_en, bus.mem_we} !== 3'b000) begin failures++; $display("FAIL abort_outputs got=%b exp=000", {bus.busy, bus.mem_en, bus.mem_we}); end
        bus.d_req = 1'b0;
        acked = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.d_ack) acked = 1'b1;
        end
        reset_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (bus.d_ack) acked = 1'b1;
        end
        checks++; if (acked !== 1'b0) begin failures++; $display("FAIL abort_no_ack got=%b exp=0", acked); end
        checks++; if ({ram[8'hFC], ram[8'hFD], ram[8'hFE], ram[8'hFF]} !== 32'hE5F63344) begin failures++; $display("FAIL abort_ram got=%h exp=e5f63344", {ram[8'hFC], ram[8'hFD], ram[8'hFE], ram[8'hFF]}); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        pl_we    = 1'b0;
        pl_addr  = 8'd0;
        pl_data  = 8'd0;
        reset_n  = 1'b1;
        clear_inputs();
        test_reset();
        test_fetch();
        test_arbitration();
        test_write_read();
        test_misaligned();
        test_dword();
        test_wrap_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
